// File: rtl/motoro3_pkg.sv
// Shared types and default constants for the motor-3 soft-start/soft-stop sequencer.
package motoro3_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        RUN   = 3'd2,
        DECEL = 3'd3,
        DWELL = 3'd4
    } state_e;

    localparam int FW_DEF          = 10;
    localparam int FREQ_MIN_DEF    = 16;
    localparam int STEP_DIV_DEF    = 10000;
    localparam int STEP_DEF        = 1;
    localparam int DWELL_TICKS_DEF = 100;

endpackage

// File: rtl/motoro3_tick_gen.sv
// Ramp-rate prescaler: one-cycle tick every DIV clocks, held at zero while restart is high.
module motoro3_tick_gen #(
    parameter int DIV = 10000
) (
    input  logic clk,
    input  logic nRst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)               cnt <= '0;
        else if (restart || tick) cnt <= '0;
        else                     cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/motoro3_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for motoro3_top: ramps m3freq at a fixed tick rate and
// turns direction reversals into decelerate, stop, dwell, restart.
module motoro3_ramp_ctrl
    import motoro3_pkg::*;
#(
    parameter int FW          = FW_DEF,
    parameter int STEP_DIV    = STEP_DIV_DEF,
    parameter int STEP        = STEP_DEF,
    parameter int FREQ_MIN    = FREQ_MIN_DEF,
    parameter int DWELL_TICKS = DWELL_TICKS_DEF
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic          cmdValid,
    output logic          cmdReady,
    input  logic          cmdRun,
    input  logic          cmdDir,
    input  logic [FW-1:0] cmdFreq,
    output logic          m3start,
    output logic          m3invOrStop,
    output logic [FW-1:0] m3freq,
    output logic          busy,
    output logic [2:0]    st
);

    localparam logic [FW-1:0]  FMIN    = FW'(FREQ_MIN);
    localparam logic [FW:0]    STEPX   = (FW+1)'(STEP);
    localparam int             DWW     = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [DWW-1:0] DW_LAST = DWW'(DWELL_TICKS - 1);

    state_e         state_q, state_d;
    logic           start_d, dir_d;
    logic [FW-1:0]  freq_d;
    logic           trun_q, trun_d, tdir_q, tdir_d;
    logic [FW-1:0]  tfreq_q, tfreq_d, rfreq_q, rfreq_d;
    logic [DWW-1:0] dwell_q, dwell_d;
    logic           tick, hs;
    logic [FW-1:0]  cmd_tgt, up_diff, dn_diff, freq_step;

    motoro3_tick_gen #(.DIV(STEP_DIV)) u_tick (
        .clk     (clk),
        .nRst    (nRst),
        .restart (state_q == IDLE),
        .tick    (tick)
    );

    assign cmdReady = (state_q != DECEL) && (state_q != DWELL);
    assign busy     = (state_q == RAMP) || (state_q == DECEL) || (state_q == DWELL);
    assign st       = state_q;
    assign hs       = cmdValid && cmdReady;
    assign cmd_tgt  = (cmdFreq < FMIN) ? FMIN : cmdFreq;

    // Saturating step toward the registered target; lands exactly when within one STEP.
    assign up_diff = tfreq_q - m3freq;
    assign dn_diff = m3freq - tfreq_q;
    always_comb begin
        freq_step = m3freq;
        if (m3freq < tfreq_q)
            freq_step = ({1'b0, up_diff} <= STEPX) ? tfreq_q : m3freq + STEPX[FW-1:0];
        else if (m3freq > tfreq_q)
            freq_step = ({1'b0, dn_diff} <= STEPX) ? tfreq_q : m3freq - STEPX[FW-1:0];
    end

    always_comb begin
        state_d = state_q;
        start_d = m3start;
        dir_d   = m3invOrStop;
        freq_d  = m3freq;
        trun_d  = trun_q;
        tdir_d  = tdir_q;
        tfreq_d = tfreq_q;
        rfreq_d = rfreq_q;
        dwell_d = dwell_q;
        if (hs) begin
            trun_d = cmdRun;
            tdir_d = cmdDir;
        end
        case (state_q)
            IDLE: begin
                if (hs && cmdRun) begin
                    state_d = RAMP;
                    start_d = 1'b1;
                    dir_d   = cmdDir;
                    freq_d  = FMIN;
                    tfreq_d = cmd_tgt;
                end
            end
            RAMP, RUN: begin
                // The step on this edge uses the old target even when a command lands now.
                if (tick) freq_d = freq_step;
                if (state_q == RAMP && tick && !hs && freq_step == tfreq_q) state_d = RUN;
                if (hs) begin
                    if (!cmdRun || cmdDir != m3invOrStop) begin
                        state_d = DECEL;
                        tfreq_d = FMIN;
                        rfreq_d = cmd_tgt;
                    end else begin
                        tfreq_d = cmd_tgt;
                        if (state_q == RUN && cmd_tgt != m3freq) state_d = RAMP;
                    end
                end
            end
            DECEL: begin
                if (m3freq <= FMIN) begin
                    state_d = DWELL;
                    start_d = 1'b0;
                    dir_d   = 1'b0;
                    freq_d  = '0;
                    dwell_d = '0;
                end else if (tick) begin
                    freq_d = freq_step;
                end
            end
            DWELL: begin
                if (tick) begin
                    if (dwell_q == DW_LAST) begin
                        if (trun_q) begin
                            state_d = RAMP;
                            start_d = 1'b1;
                            dir_d   = tdir_q;
                            freq_d  = FMIN;
                            tfreq_d = rfreq_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            m3start     <= 1'b0;
            m3invOrStop <= 1'b0;
            m3freq      <= '0;
            trun_q      <= 1'b0;
            tdir_q      <= 1'b0;
            tfreq_q     <= '0;
            rfreq_q     <= '0;
            dwell_q     <= '0;
        end else begin
            state_q     <= state_d;
            m3start     <= start_d;
            m3invOrStop <= dir_d;
            m3freq      <= freq_d;
            trun_q      <= trun_d;
            tdir_q      <= tdir_d;
            tfreq_q     <= tfreq_d;
            rfreq_q     <= rfreq_d;
            dwell_q     <= dwell_d;
        end
    end

endmodule

// File: tb/tb_motoro3_ramp_ctrl.sv
// Scoreboard bench: expected output changes (value plus clocks since previous change) are queued
// by the stimulus and popped by a monitor whenever the motor outputs change.
module tb_motoro3_ramp_ctrl;
    import motoro3_pkg::*;

    localparam int FW = 10;

    logic          clk = 1'b0, nRst = 1'b0;
    logic          cmdValid = 1'b0, cmdRun = 1'b0, cmdDir = 1'b0;
    logic [FW-1:0] cmdFreq = '0;
    logic          cmdReady, m3start, m3invOrStop, busy;
    logic [FW-1:0] m3freq;
    logic [2:0]    st;

    int errors = 0, checks = 0, cyc = 0, last_cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic          s;
        logic          d;
        logic [FW-1:0] f;
        int            gap;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    logic [FW+1:0] prev_out = '0, cur_out;

    motoro3_ramp_ctrl #(
        .FW(FW), .STEP_DIV(4), .STEP(2), .FREQ_MIN(8), .DWELL_TICKS(3)
    ) dut (
        .clk(clk), .nRst(nRst), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdRun(cmdRun), .cmdDir(cmdDir), .cmdFreq(cmdFreq),
        .m3start(m3start), .m3invOrStop(m3invOrStop), .m3freq(m3freq),
        .busy(busy), .st(st)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every change of the motor outputs must match the next queued expectation.
    initial forever begin
        @(negedge clk);
        cur_out = {m3start, m3invOrStop, m3freq};
        if (mon_en && cur_out != prev_out) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got start=%0b dir=%0b freq=%0d, nothing expected",
                         m3start, m3invOrStop, m3freq);
            end else begin
                mon_e = sbq.pop_front();
                if ({mon_e.s, mon_e.d, mon_e.f} != cur_out ||
                    (mon_e.gap != 0 && cyc - last_cyc != mon_e.gap)) begin
                    errors++;
                    $display("FAIL sb_entry: got start=%0b dir=%0b freq=%0d gap=%0d, want start=%0b dir=%0b freq=%0d gap=%0d",
                             m3start, m3invOrStop, m3freq, cyc - last_cyc,
                             mon_e.s, mon_e.d, mon_e.f, mon_e.gap);
                end
            end
            prev_out = cur_out;
            last_cyc = cyc;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic s, input logic d, input int f, input int gap);
        exp_t e;
        e.s = s; e.d = d; e.f = FW'(f); e.gap = gap;
        sbq.push_back(e);
    endtask

    // Hold cmdValid from a negedge until the DUT is ready, then drop it just after the accepting edge.
    task automatic send(input logic run, input logic dir, input int freq);
        int n = 0;
        @(negedge clk);
        cmdValid = 1'b1; cmdRun = run; cmdDir = dir; cmdFreq = FW'(freq);
        while (!cmdReady && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", int'(cmdReady), 1);
        if (cmdReady) begin
            @(posedge clk);
            #1;
        end
        cmdValid = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int bound);
        int n = 0;
        while (sbq.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(nm, sbq.size(), 0);
    endtask

    task automatic wait_st(input string nm, input state_e s, input int bound);
        int n = 0;
        while (st != 3'(s) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(st), int'(s));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_st", int'(st), int'(IDLE));
        chk("rst_start", int'(m3start), 0);
        chk("rst_dir", int'(m3invOrStop), 0);
        chk("rst_freq", int'(m3freq), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmdReady), 1);

        // 1: start forward to 20
        push(1, 0, 8, 0);
        for (int f = 10; f <= 20; f += 2) push(1, 0, f, 4);
        send(1, 0, 20);
        wait_drain("s1_drain", 100);
        wait_st("s1_run", RUN, 8);
        chk("s1_busy", int'(busy), 0);

        // same command while running: no change
        send(1, 0, 20);
        repeat (10) @(negedge clk);
        chk("same_st", int'(st), int'(RUN));
        chk("same_busy", int'(busy), 0);

        // 2: retarget down with saturating last step, then clamp to FREQ_MIN
        push(1, 0, 18, 0); push(1, 0, 16, 4); push(1, 0, 15, 4);
        send(1, 0, 15);
        wait_drain("s2a_drain", 100);
        wait_st("s2a_run", RUN, 8);
        push(1, 0, 13, 0); push(1, 0, 11, 4); push(1, 0, 9, 4); push(1, 0, 8, 4);
        send(1, 0, 3);
        wait_drain("s2b_drain", 100);
        wait_st("s2b_run", RUN, 8);
        chk("s2b_freq", int'(m3freq), 8);
        push(1, 0, 10, 0);
        for (int f = 12; f <= 20; f += 2) push(1, 0, f, 4);
        send(1, 0, 20);
        wait_drain("s2c_drain", 100);
        wait_st("s2c_run", RUN, 8);

        // 3: reversal: decel, stop, 3-tick dwell, restart reversed
        push(1, 0, 18, 0);
        for (int f = 16; f >= 8; f -= 2) push(1, 0, f, 4);
        push(0, 0, 0, 1);
        push(1, 1, 8, 11);
        for (int f = 10; f <= 20; f += 2) push(1, 1, f, 4);
        send(1, 1, 20);
        @(negedge clk);
        chk("s3_decel", int'(st), int'(DECEL));
        chk("s3_ready", int'(cmdReady), 0);
        chk("s3_busy", int'(busy), 1);
        wait_drain("s3_drain", 200);
        wait_st("s3_run", RUN, 8);
        chk("s3_dir", int'(m3invOrStop), 1);

        // 4: stop, with the next command held off until IDLE
        push(1, 1, 18, 0);
        for (int f = 16; f >= 8; f -= 2) push(1, 1, f, 4);
        push(0, 0, 0, 1);
        push(1, 0, 8, 12); push(1, 0, 10, 4); push(1, 0, 12, 4);
        fork
            begin
                send(0, 0, 0);
                send(1, 0, 12);
            end
            begin
                wait_st("s4_idle", IDLE, 300);
                chk("s4_idle_busy", int'(busy), 0);
                chk("s4_idle_ready", int'(cmdReady), 1);
            end
        join
        wait_drain("s4_drain", 100);
        wait_st("s4_run", RUN, 8);

        // 5: asynchronous reset mid-ramp
        push(1, 0, 14, 0); push(1, 0, 16, 4);
        send(1, 0, 30);
        wait_drain("s5_drain", 100);
        push(0, 0, 0, 0);
        @(posedge clk);
        #2 nRst = 1'b0;
        #1;
        chk("s5_start", int'(m3start), 0);
        chk("s5_freq", int'(m3freq), 0);
        chk("s5_st", int'(st), int'(IDLE));
        chk("s5_busy", int'(busy), 0);
        chk("s5_ready", int'(cmdReady), 1);
        repeat (3) @(negedge clk);
        #2 nRst = 1'b1;
        repeat (12) @(negedge clk);
        chk("s5_post_st", int'(st), int'(IDLE));
        chk("s5_post_start", int'(m3start), 0);
        chk("s5_post_drain", sbq.size(), 0);

        // stop while idle: accepted, no effect
        send(0, 1, 50);
        repeat (10) @(negedge clk);
        chk("idle_stop_st", int'(st), int'(IDLE));
        chk("idle_stop_busy", int'(busy), 0);

        // 6: command handshake on the same edge as a tick
        push(1, 0, 8, 0); push(1, 0, 10, 4); push(1, 0, 12, 4); push(1, 0, 11, 4);
        send(1, 0, 20);
        repeat (7) @(posedge clk);
        @(negedge clk);
        cmdValid = 1'b1; cmdRun = 1'b1; cmdDir = 1'b0; cmdFreq = FW'(11);
        @(posedge clk);
        #1 cmdValid = 1'b0;
        wait_drain("s6_drain", 100);
        wait_st("s6_run", RUN, 8);
        chk("s6_freq", int'(m3freq), 11);
        repeat (10) @(negedge clk);
        chk("end_drain", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motoro3_ramp_ctrl.md
Name: motoro3_ramp_ctrl

Overview:
Soft-start/soft-stop sequencer in the clkM3 (10 MHz) domain that drives the m3start, m3invOrStop and m3freq inputs of motoro3_top.
- Accepts run/direction/target-frequency commands over a valid/ready handshake.
- Ramps m3freq toward the target at a fixed step rate.
- Handles direction reversal as decelerate, stop, dwell, restart reversed, so the bridge never sees an abrupt reversal.

Parameters:
FW, 10, width of frequency command/output (matches m3freq).
STEP_DIV, 10000, clk cycles per ramp tick (1 kHz tick at 10 MHz).
STEP, 1, m3freq change per ramp tick.
FREQ_MIN, 16, start/stop frequency; a running target is never below this.
DWELL_TICKS, 100, ramp ticks held stopped before a reversed restart.

Ports:
clk  in  1  clkM3 domain clock, 10 MHz.
nRst  in  1  asynchronous active-low reset.
cmdValid  in  1  command present.
cmdReady  out  1  command accepted when cmdValid&cmdReady at a rising clk edge.
cmdRun  in  1  1 = run, 0 = stop.
cmdDir  in  1  0 = forward, 1 = reverse.
cmdFreq  in  FW  target frequency.
m3start  out  1  motor run enable to motoro3_top.
m3invOrStop  out  1  direction to motoro3_top while m3start=1 (1 = reverse); held 0 while stopped.
m3freq  out  FW  current commanded frequency.
busy  out  1  1 while m3freq != target or a stop/reversal sequence is active.
st  out  3  current state encoding, for debug/test points.

Behaviour:
Reset (nRst=0, asynchronous) drives:
- st=IDLE; m3start=0; m3invOrStop=0; m3freq=0; busy=0; cmdReady=1.
- Target registers and prescaler = 0.
- A reset mid-ramp or mid-dwell aborts immediately; no sequence resumes after reset release.

Ramp tick:
- Free-running prescaler counts 0..STEP_DIV-1; tick is a 1-cycle pulse when the count = STEP_DIV-1.
- The prescaler restarts from 0 when leaving IDLE.
- All m3freq changes happen only on tick cycles.

Command capture:
- Captured on handshake into tgtRun, tgtDir, tgtFreq.
- tgtFreq = max(cmdFreq, FREQ_MIN) when cmdRun=1.
- cmdReady=0 in DECEL and DWELL; it is 1 in all other states.
- A new command in RAMP/RUN overrides the target with no restart.
- cmdValid with cmdReady=0 is held off; the sender keeps cmdValid high until accepted.

Ramp step on tick:
- m3freq moves by STEP toward tgtFreq.
- Saturating: never overshoots; when |diff| < STEP, m3freq = tgtFreq exactly.
- No wrap at 0 or 2^FW-1.

States:
- IDLE: accept tgtRun=1 -> set m3freq=FREQ_MIN, m3invOrStop=tgtDir, m3start=1 on the next cycle -> RAMP.
- RAMP: step each tick. m3freq==tgtFreq -> RUN. Accepted command with cmdRun=0, or cmdDir != m3invOrStop -> DECEL (set tgtFreq=FREQ_MIN internally, remember the pending request).
- RUN: busy=0. Any new target -> RAMP. Stop or direction change -> DECEL.
- DECEL: step toward FREQ_MIN. On reaching FREQ_MIN -> m3start=0, m3invOrStop=0, m3freq=0 -> DWELL.
- DWELL: count DWELL_TICKS ticks. On expiry: pending reverse-run -> m3invOrStop=new dir, m3freq=FREQ_MIN, m3start=1, tgtFreq=requested -> RAMP. Pending stop -> IDLE.

Boundary and simultaneous-event rules:
- Stop command while in IDLE: accepted, no effect.
- Run command with the same direction and the same frequency as current in RUN: stays in RUN, busy stays 0.
- Tick coincident with a command handshake: the step uses the old target; the new target applies from the next tick.
- busy=1 in RAMP, DECEL and DWELL; busy=0 in IDLE and RUN.

Decomposition:
- Shared package motoro3_pkg holds:
  - State enum: IDLE=0, RAMP=1, RUN=2, DECEL=3, DWELL=4.
  - Default FW, FREQ_MIN and STEP_DIV constants, also used by the top-level defines.
- One sub-module: motoro3_tick_gen (prescaler with restart input, tick output).
- Ramp stepper and FSM stay in the parent block.

Test Plan:
Bench parameters for all scenarios: STEP_DIV=4, STEP=2, FREQ_MIN=8, DWELL_TICKS=3.
1. Reset then cmd{run=1, dir=0, freq=20}:
   - Next cycle: m3start=1, m3freq=8.
   - m3freq steps 10,12,...,20, one step every 4 clks.
   - st=RUN and busy=0 after 6 ticks.
2. In RUN at 20, cmd freq=15:
   - m3freq goes 18,16,15 (saturating final step), then RUN.
   - cmd freq=3 -> target clamps to 8.
3. In RUN at 20, cmd dir=1:
   - cmdReady=0; m3freq ramps down to 8; then m3start=0, m3freq=0.
   - Dwell lasts 3 ticks (12 clks).
   - Restart: m3invOrStop=1, m3freq=8, ramps up to 20.
4. In RUN, cmd run=0:
   - Decel to 8, then stop, dwell, IDLE; busy falls on entering IDLE.
   - cmdValid held during DECEL is accepted only after IDLE.
5. Assert nRst=0 mid-RAMP, asynchronously between clk edges:
   - All outputs go to reset values immediately.
   - After release, outputs stay idle until a new command arrives.
6. cmdValid asserted on the same cycle as a tick in RAMP:
   - That step uses the old target; the new target applies from the next tick.
   - cmdValid=1, cmdReady=1 for one cycle gives exactly one capture.
